// File: rtl/systolic_input_sequencer.sv
// systolic_input_sequencer: buffers upstream samples in a small FIFO and
// presents one sample to the systolic array every FRAME_LEN clk30x cycles,
// with a frame phase counter, a frame_start pulse and underflow tracking.
// Build option: define SEQ_UNDERFLOW_HOLD_EN to hold the previous xin on an
// underflow frame; otherwise an underflow frame drives xin to zero.
//
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is simply NOT full (a pop in the same cycle grants no
// credit), and in_valid/in_data may change freely while in_ready is 0.
module systolic_input_sequencer #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk30x,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] xin,
  output logic [31:0]       timing,
  output logic              frame_start,
  output logic              underflow,
  output logic [7:0]        underflow_cnt,
  output logic              dbg_state
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] LAST_C  = 32'(FRAME_LEN - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] xin_q, xin_d;
  logic [31:0]       timing_q, timing_d;
  logic              fs_q, fs_d;
  logic              uf_q, uf_d;
  logic [7:0]        ucnt_q, ucnt_d;

  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  // Occupancy from extra-bit wrapping pointers.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign in_ready      = ~full;
  assign xin           = xin_q;
  assign timing        = timing_q;
  assign frame_start   = fs_q;
  assign underflow     = uf_q;
  assign underflow_cnt = ucnt_q;
  assign dbg_state     = state_q;

  // Next-state logic: flush wins, otherwise frame sequencing and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    timing_d = timing_q;
    fs_d     = 1'b0;
    xin_d    = xin_q;
    uf_d     = uf_q;
    ucnt_d   = ucnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;
    push     = in_valid & ~full;
    if (flush) begin
      state_d  = S_IDLE;
      timing_d = '0;
      xin_d    = '0;
      uf_d     = 1'b0;
      ucnt_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      push     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          timing_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            xin_d   = head;
            fs_d    = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (timing_q == LAST_C) begin
            timing_d = '0;
            fs_d     = 1'b1;
            if (!empty) begin
              pop   = 1'b1;
              xin_d = head;
            end else begin
              // Pop decision uses pre-edge occupancy, so a same-edge push
              // cannot bypass into xin.
              uf_d = 1'b1;
              if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
`ifdef SEQ_UNDERFLOW_HOLD_EN
              xin_d = xin_q;
`else
              xin_d = '0;
`endif
            end
          end else begin
            timing_d = timing_q + 32'd1;
          end
        end
      endcase
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Control and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk30x or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      xin_q    <= '0;
      timing_q <= '0;
      fs_q     <= 1'b0;
      uf_q     <= 1'b0;
      ucnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      xin_q    <= xin_d;
      timing_q <= timing_d;
      fs_q     <= fs_d;
      uf_q     <= uf_d;
      ucnt_q   <= ucnt_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk30x) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: doc/systolic_input_sequencer.md
SYSTOLIC_INPUT_SEQUENCER -- requirements
Module: systolic_input_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width, equal to the systolic_wrapper xin width.
REQ-002 SHALL have parameter FRAME_LEN, default 30: clk30x cycles per sample frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: input buffer entries, a power of two, minimum 2.
REQ-004 SHALL have port clk30x, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of the buffer and state, active high.
REQ-007 SHALL have port in_data, input, DATA_W bits: upstream sample.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: buffer can accept a sample.
REQ-010 SHALL have port xin, output, DATA_W bits: sample presented to the array, held for one frame.
REQ-011 SHALL have port timing, output, 32 bits: frame phase, 0..FRAME_LEN-1.
REQ-012 SHALL have port frame_start, output, 1 bit: single-cycle pulse on the first cycle of each frame.
REQ-013 SHALL have port underflow, output, 1 bit: sticky; set when a frame boundary finds the buffer empty.
REQ-014 SHALL have port underflow_cnt, output, 8 bits: count of underflow frames, saturating at 255.

Function
REQ-015 SHALL accept a push when in_valid and in_ready are both 1 on a rising edge; in_ready SHALL equal NOT full, with no same-cycle pop credit.
REQ-016 SHALL implement a FIFO of FIFO_DEPTH entries with wrapping pointers; a push while full SHALL never occur.
REQ-017 SHALL run a two-state machine, IDLE and RUN.
REQ-018 In IDLE, SHALL hold timing=0, xin unchanged and frame_start=0.
REQ-019 SHALL leave IDLE when the FIFO is non-empty; on the next edge it SHALL pop the head into xin, set timing=0, pulse frame_start and enter RUN.
REQ-020 In RUN, SHALL increment timing by 1 each cycle while timing<FRAME_LEN-1.
REQ-021 In RUN at timing=FRAME_LEN-1, the next edge SHALL set timing=0, pulse frame_start, and pop the head into xin if the FIFO is non-empty.
REQ-022 SHALL therefore present a new xin value exactly every FRAME_LEN cycles, with one cycle of latency from the frame boundary.
REQ-023 If the FIFO is empty at a frame boundary, SHALL take the underflow action (REQ-030/031), set underflow, increment underflow_cnt, and stay in RUN.
REQ-024 SHALL have no push-to-pop bypass: a sample pushed on the boundary edge while the FIFO is empty SHALL count as an underflow and be popped at the next boundary.
REQ-025 With a simultaneous push and pop, occupancy SHALL be unchanged and data order SHALL be preserved.
REQ-026 On flush, SHALL empty the FIFO, enter IDLE, set timing=0, frame_start=0 and xin=0, and clear underflow and underflow_cnt; flush SHALL take precedence over a push in the same cycle.

Reset
REQ-027 On rst_n=0, SHALL immediately force xin=0, timing=0, frame_start=0, underflow=0, underflow_cnt=0, in_ready=1, the FIFO empty and the state IDLE, regardless of the clock.
REQ-028 SHALL discard an in-progress frame when reset is asserted mid-frame, with no partial pop retained.
REQ-029 After rst_n deasserts, the first edge SHALL behave as an IDLE cycle.

Configuration
REQ-030 With SEQ_UNDERFLOW_HOLD_EN defined, an underflow frame SHALL keep xin at its previous value.
REQ-031 Without SEQ_UNDERFLOW_HOLD_EN, an underflow frame SHALL drive xin=0; flag and count behaviour are identical in both builds.

Verification
REQ-032 Reset, then push 0x0001 and 0x0002 back-to-back -> frame_start at cycle 2 with xin=0x0001 and timing=0; xin=0x0002 at cycle 32; timing reaches 29 before each wrap.
REQ-033 Push 4 samples with no frame boundary pending, then hold in_valid=1 -> in_ready=0 after the 4th push; no 5th sample is lost or overwritten.
REQ-034 Start a frame with one buffered sample 0x7FFF and make no further pushes -> at the next boundary underflow=1, underflow_cnt=1, and xin=0x0000 (or 0x7FFF with SEQ_UNDERFLOW_HOLD_EN).
REQ-035 Force 300 consecutive underflow frames -> underflow_cnt saturates at 255 and underflow stays 1 until flush.
REQ-036 Assert rst_n=0 at timing=17 with 3 samples buffered -> all outputs reset asynchronously, the buffer is empty, and the sequence restarts cleanly from IDLE.
REQ-037 Assert flush and in_valid in the same cycle -> the FIFO is empty, in_ready=1, and the pushed sample is dropped.
